// File: rtl/vga_sprite_engine.sv
// ============================================================================
// Module   : vga_sprite_engine
// Purpose  : VGA timing generator with NUM_OBJ filled-rectangle renderer.
//            The pixel pipeline has three stages: counters, then sync/blank
//            decode and per-object hit, then a colour mux into the output
//            registers. Object parameters are shadow-latched once per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sprite_engine #(
  parameter int          H_DISPLAY = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_DISPLAY = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter int          COORD_W   = 10,
  parameter int          NUM_OBJ   = 4,
  parameter logic [23:0] BG_RGB    = 24'h0C01B5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_en_i,
  input  logic [NUM_OBJ-1:0]         obj_en_i,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_x_i,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_y_i,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_w_i,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_h_i,
  input  logic [NUM_OBJ*24-1:0]      obj_rgb_i,
  output logic [7:0]                 red_o,
  output logic [7:0]                 green_o,
  output logic [7:0]                 blue_o,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic                       blankN_o,
  output logic [COORD_W-1:0]         hcount_o,
  output logic [COORD_W-1:0]         vcount_o,
  output logic                       frame_start_o
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_DISP_C = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_DISP_C = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

  // Stage 1: raster counters
  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic               frame_end;

  // Shadow copies of the object inputs, used for all rendering
  logic [NUM_OBJ-1:0]         sh_en_q;
  logic [NUM_OBJ*COORD_W-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q;
  logic [NUM_OBJ*24-1:0]      sh_rgb_q;

  // Stage 2: decoded timing and hit vector
  logic [COORD_W-1:0] s2_h_q, s2_v_q;
  logic               s2_hs_q, s2_vs_q, s2_blank_q, s2_fs_q;
  logic [NUM_OBJ-1:0] s2_hit_q, hit_d;
  logic               hs_d, vs_d, blank_d;

  // Stage 3: output registers
  logic [23:0]        rgb_d, rgb_q;
  logic [COORD_W-1:0] hcount_q, vcount_q;
  logic               hsync_q, vsync_q, blank_q, fs_q;

  assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);

  // Next raster position: h wraps at end of line, v wraps at end of frame
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Raster counter register, advancing once per pixel enable
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_en_i) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Capture object inputs at the last pixel of the frame so the next frame
  // renders from one consistent snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en_q  <= '0;
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      sh_w_q   <= '0;
      sh_h_q   <= '0;
      sh_rgb_q <= '0;
    end else if (pix_en_i && frame_end) begin
      sh_en_q  <= obj_en_i;
      sh_x_q   <= obj_x_i;
      sh_y_q   <= obj_y_i;
      sh_w_q   <= obj_w_i;
      sh_h_q   <= obj_h_i;
      sh_rgb_q <= obj_rgb_i;
    end
  end

  // Per-object hit test; edges are summed one bit wider so x+w never wraps
  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_hit
    logic [COORD_W-1:0] x_s, y_s;
    logic [COORD_W:0]   x_end, y_end;
    assign x_s   = sh_x_q[gi*COORD_W +: COORD_W];
    assign y_s   = sh_y_q[gi*COORD_W +: COORD_W];
    assign x_end = {1'b0, x_s} + {1'b0, sh_w_q[gi*COORD_W +: COORD_W]};
    assign y_end = {1'b0, y_s} + {1'b0, sh_h_q[gi*COORD_W +: COORD_W]};
    assign hit_d[gi] = sh_en_q[gi] &&
                       (h_q >= x_s) && ({1'b0, h_q} < x_end) &&
                       (v_q >= y_s) && ({1'b0, v_q} < y_end);
  end

  assign hs_d    = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_d    = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign blank_d = (h_q < H_DISP_C) && (v_q < V_DISP_C);

  // Stage 2 register: timing decode and hits for the counter position
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_h_q     <= '0;
      s2_v_q     <= '0;
      s2_hs_q    <= 1'b1;
      s2_vs_q    <= 1'b1;
      s2_blank_q <= 1'b0;
      s2_fs_q    <= 1'b0;
      s2_hit_q   <= '0;
    end else if (pix_en_i) begin
      s2_h_q     <= h_q;
      s2_v_q     <= v_q;
      s2_hs_q    <= hs_d;
      s2_vs_q    <= vs_d;
      s2_blank_q <= blank_d;
      s2_fs_q    <= (h_q == '0) && (v_q == '0);
      s2_hit_q   <= hit_d;
    end
  end

  // Colour select: blanked -> black, else lowest-index hit, else background
  always_comb begin
    rgb_d = BG_RGB;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (s2_hit_q[i]) rgb_d = sh_rgb_q[i*24 +: 24];
    end
    if (!s2_blank_q) rgb_d = 24'h000000;
  end

  // Stage 3 register: all outputs leave from here, mutually aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      blank_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else if (pix_en_i) begin
      rgb_q    <= rgb_d;
      hcount_q <= s2_h_q;
      vcount_q <= s2_v_q;
      hsync_q  <= s2_hs_q;
      vsync_q  <= s2_vs_q;
      blank_q  <= s2_blank_q;
      fs_q     <= s2_fs_q;
    end
  end

  assign red_o         = rgb_q[23:16];
  assign green_o       = rgb_q[15:8];
  assign blue_o        = rgb_q[7:0];
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign blankN_o      = blank_q;
  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign frame_start_o = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
// ============================================================================
// Module   : tb_vga_sprite_engine
// Purpose  : Directed bench for vga_sprite_engine in a small 24x17 raster mode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sprite_engine;

  localparam int HD = 16, HF = 2, HS = 3, HB = 3;
  localparam int VD = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;   // 24
  localparam int VT = VD + VF + VS + VB;   // 17
  localparam int CW = 6;
  localparam int NO = 2;
  localparam logic [23:0] BG = 24'h0C01B5;
  localparam logic [39:0] RESET_V = {6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'd0};

  logic              clk, rst, pix_en;
  logic [NO-1:0]     obj_en;
  logic [NO*CW-1:0]  obj_x, obj_y, obj_w, obj_h;
  logic [NO*24-1:0]  obj_rgb;
  logic [7:0]        red, green, blue;
  logic              hsync, vsync, blank_n, fs;
  logic [CW-1:0]     hcount, vcount;

  // Object inputs as driven, and the snapshot the DUT should be rendering
  logic [CW-1:0] ox[NO], oy[NO], ow[NO], oh[NO];
  logic [23:0]   orgb[NO];
  logic          oen[NO];
  logic [CW-1:0] sx[NO], sy[NO], sw[NO], sh[NO];
  logic [23:0]   srgb[NO];
  logic          sen[NO];

  int vectors = 0;
  int errors  = 0;

  vga_sprite_engine #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COORD_W(CW), .NUM_OBJ(NO), .BG_RGB(BG)
  ) dut (
    .clk(clk), .rst(rst), .pix_en_i(pix_en),
    .obj_en_i(obj_en), .obj_x_i(obj_x), .obj_y_i(obj_y),
    .obj_w_i(obj_w), .obj_h_i(obj_h), .obj_rgb_i(obj_rgb),
    .red_o(red), .green_o(green), .blue_o(blue),
    .hsync_o(hsync), .vsync_o(vsync), .blankN_o(blank_n),
    .hcount_o(hcount), .vcount_o(vcount), .frame_start_o(fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-object arrays onto the flat input buses
  always_comb begin
    obj_en = '0; obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0; obj_rgb = '0;
    for (int i = 0; i < NO; i++) begin
      obj_en[i]            = oen[i];
      obj_x[i*CW +: CW]    = ox[i];
      obj_y[i*CW +: CW]    = oy[i];
      obj_w[i*CW +: CW]    = ow[i];
      obj_h[i*CW +: CW]    = oh[i];
      obj_rgb[i*24 +: 24]  = orgb[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected colour of a pixel given the current snapshot
  function automatic logic [23:0] exp_rgb(int h, int v);
    if (h >= HD || v >= VD) return 24'h000000;
    for (int i = 0; i < NO; i++) begin
      if (sen[i] && h >= int'(sx[i]) && h < int'(sx[i]) + int'(sw[i]) &&
          v >= int'(sy[i]) && v < int'(sy[i]) + int'(sh[i]))
        return srgb[i];
    end
    return BG;
  endfunction

  function automatic logic [39:0] exp_vec(int h, int v);
    logic e_hs, e_vs, e_bl, e_fs;
    e_hs = !(h >= HD + HF && h < HD + HF + HS);
    e_vs = !(v >= VD + VF && v < VD + VF + VS);
    e_bl = (h < HD) && (v < VD);
    e_fs = (h == 0) && (v == 0);
    return {CW'(h), CW'(v), e_hs, e_vs, e_bl, e_fs, exp_rgb(h, v)};
  endfunction

  // Hand-picked pixels: returns {found, rgb}
  function automatic logic [24:0] lit(int f, int h, int v);
    case (f * 10000 + h * 100 + v)
      302:   return {1'b1, BG};
      10302: return {1'b1, 24'hFF0000};
      10202: return {1'b1, BG};
      10702: return {1'b1, 24'hFF0000};
      10802: return {1'b1, BG};
      10603: return {1'b1, 24'hFF0000};
      10904: return {1'b1, 24'h00FF00};
      11104: return {1'b1, BG};
      10705: return {1'b1, 24'h00FF00};
      10305: return {1'b1, BG};
      10906: return {1'b1, 24'h00FF00};
      11006: return {1'b1, 24'h00FF00};
      21002: return {1'b1, 24'hFF0000};
      21402: return {1'b1, 24'hFF0000};
      21502: return {1'b1, BG};
      20302: return {1'b1, BG};
      21203: return {1'b1, 24'hFF0000};
      21503: return {1'b1, 24'h00FF00};
      21506: return {1'b1, 24'h00FF00};
      21105: return {1'b1, BG};
      21507: return {1'b1, BG};
      21603: return {1'b1, 24'h000000};
      default: return 25'd0;
    endcase
  endfunction

  task automatic check(string tag, logic [39:0] expv);
    logic [39:0] obs;
    obs = {hcount, vcount, hsync, vsync, blank_n, fs, red, green, blue};
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_rgb(string tag, logic [23:0] expc);
    vectors++;
    assert ({red, green, blue} === expc) else begin
      errors++;
      $error("FAIL %s: observed rgb %h expected %h", tag, {red, green, blue}, expc);
    end
  endtask

  task automatic latch_model();
    for (int i = 0; i < NO; i++) begin
      sx[i] = ox[i]; sy[i] = oy[i]; sw[i] = ow[i]; sh[i] = oh[i];
      srgb[i] = orgb[i]; sen[i] = oen[i];
    end
  endtask

  // Walk one frame from output pixel (0,0), stopping early at line vstop.
  // In slow mode pix_en is high one cycle in four and outputs must hold.
  task automatic scan(int f, int vstop, bit slow);
    logic [24:0] l;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (v == vstop) return;
        check($sformatf("px f%0d (%0d,%0d)", f, h, v), exp_vec(h, v));
        l = lit(f, h, v);
        if (l[24]) check_rgb($sformatf("lit f%0d (%0d,%0d)", f, h, v), l[23:0]);
        if (f == 1 && h == 0 && v == 6) begin
          ox[0] = 6'd10;
          ox[1] = 6'd12;
          ow[1] = 6'd60;
        end
        if (slow) begin
          pix_en = 1'b0;
          for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold f%0d (%0d,%0d)", f, h, v), exp_vec(h, v));
          end
          pix_en = 1'b1;
        end
        tick();
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    ox[0] = 6'd3; oy[0] = 6'd2; ow[0] = 6'd5; oh[0] = 6'd3; orgb[0] = 24'hFF0000; oen[0] = 1'b1;
    ox[1] = 6'd5; oy[1] = 6'd3; ow[1] = 6'd6; oh[1] = 6'd4; orgb[1] = 24'h00FF00; oen[1] = 1'b1;
    for (int i = 0; i < NO; i++) begin
      sx[i] = '0; sy[i] = '0; sw[i] = '0; sh[i] = '0; srgb[i] = '0; sen[i] = 1'b0;
    end
    repeat (3) tick();
    rst = 1'b0;
    check("reset", RESET_V);

    // Two enables fill the pipeline before pixel (0,0) reaches the outputs
    pix_en = 1'b1;
    tick();
    check("fill", RESET_V);
    tick();

    scan(0, VT, 1'b0);   // objects not yet latched: background only
    latch_model();
    scan(1, VT, 1'b0);   // inputs change at line 6, must not show here
    latch_model();
    scan(2, VT, 1'b0);   // moved obj0, wide obj1 clipped at display edge
    latch_model();
    scan(3, VT, 1'b1);   // same image with 1-in-4 pixel enable
    latch_model();
    scan(4, 7, 1'b0);    // stop at line 7 and reset mid-frame

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset", RESET_V);
    for (int i = 0; i < NO; i++) sen[i] = 1'b0;
    tick();
    check("mid_fill", RESET_V);
    tick();
    scan(5, VT, 1'b0);   // restarts at (0,0) with objects disabled

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
